keypad_front_end: RTL

- Producer side of the combination-lock button interface.
- Takes raw, asynchronous, bouncing switch inputs: four digit keys, enter and clear.
- Synchronises and debounces each input, then merges near-simultaneous presses into one event.
- Emits each event as a single-cycle pulse on btn/enter/clear, ready to wire straight into the lock FSM; one press gives exactly one pulse.

---
 rtl/keypad_front_end_if.sv | 22 ++
 rtl/keypad_front_end.sv | 111 +++++++++++
 2 files changed

// File: rtl/keypad_front_end_if.sv
// Button bundle between the raw switch inputs, the keypad front end and the lock FSM.
// The front end uses the master view; whoever drives the switches and consumes the pulses uses the slave view.
interface keypad_front_end_if;
    logic [3:0] raw_btn;
    logic       raw_enter;
    logic       raw_clear;
    logic [3:0] btn;
    logic       enter;
    logic       clear;
    logic       held;
    logic [7:0] event_count;

    modport master (
        input  raw_btn, raw_enter, raw_clear,
        output btn, enter, clear, held, event_count
    );

    modport slave (
        output raw_btn, raw_enter, raw_clear,
        input  btn, enter, clear, held, event_count
    );
endinterface

// File: rtl/keypad_front_end.sv
// Keypad front end: synchronise and debounce six switches, merge near-simultaneous
// presses over a short window, and emit each event as a single-cycle pulse.
module keypad_front_end #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COMBO_CYCLES    = 4,
    parameter int CNT_W           = 8
) (
    input logic                clk,
    input logic                reset,
    keypad_front_end_if.master kp
);
    localparam int              N_IN     = 6;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(COMBO_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT, HELD} state_t;

    // Vector order throughout is {clear, enter, btn[3:0]}.
    logic [N_IN-1:0]  raw;
    logic [N_IN-1:0]  sync_q1;
    logic [N_IN-1:0]  sync_q2;
    logic [N_IN-1:0]  stable;
    logic [CNT_W-1:0] db_cnt [N_IN];

    state_t           state;
    state_t           state_d;
    logic [N_IN-1:0]  acc;
    logic [N_IN-1:0]  acc_d;
    logic [CNT_W-1:0] win;
    logic [CNT_W-1:0] win_d;
    logic [7:0]       count;
    logic [N_IN-1:0]  pulse;

    assign raw = {kp.raw_clear, kp.raw_enter, kp.raw_btn};

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // NOTE: the per-input counter array is reset too, so a key held through reset restarts its debounce.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < N_IN; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync_q2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync_q2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            win   <= '0;
            count <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            win   <= win_d;
            if (state == EMIT) count <= count + 8'd1;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        win_d   = win;
        case (state)
            IDLE: begin
                if (stable != '0) begin
                    state_d = COLLECT;
                    acc_d   = stable;
                    win_d   = '0;
                end
            end
            COLLECT: begin
                // A release inside the window does not cancel; whatever was seen is reported.
                acc_d = acc | stable;
                if (win == WIN_LAST) state_d = EMIT;
                else                 win_d   = win + CNT_W'(1);
            end
            EMIT:    state_d = HELD;
            HELD:    if (stable == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pulse          = (state == EMIT) ? acc : '0;
    assign kp.btn         = pulse[3:0];
    assign kp.enter       = pulse[4];
    assign kp.clear       = pulse[5];
    assign kp.held        = (state != IDLE);
    assign kp.event_count = count;
endmodule
